// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor handshake bundle for the branch resolve queue.
// The slave side is the queue, the master side drives allocations and resolves.
interface branch_resolve_queue_if;
   logic        alloc_valid;
   logic [31:0] alloc_pc;
   logic        alloc_pred;
   logic [31:0] alloc_target;
   logic        alloc_ready;
   logic        res_valid;
   logic        res_taken;
   logic [31:0] res_target;
   logic        upd_branch;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        flush;
   logic [31:0] redirect_pc;

   modport slave (
      input  alloc_valid, alloc_pc, alloc_pred, alloc_target,
      input  res_valid, res_taken, res_target,
      output alloc_ready,
      output upd_branch, upd_pc, upd_taken,
      output flush, redirect_pc
   );

   modport master (
      output alloc_valid, alloc_pc, alloc_pred, alloc_target,
      output res_valid, res_taken, res_target,
      input  alloc_ready,
      input  upd_branch, upd_pc, upd_taken,
      input  flush, redirect_pc
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; checks each against its resolution,
// trains the predictor and squashes younger entries on a misprediction.
module branch_resolve_queue #(
   parameter int DEPTH    = 4,
   parameter int PTR_BITS = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   branch_resolve_queue_if.slave bus,
   output logic [PTR_BITS:0]   count,
   output logic                err_underflow
);

   logic [31:0]         pc_q  [DEPTH];
   logic                pred_q[DEPTH];
   logic [31:0]         tgt_q [DEPTH];

   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS:0]   count_q, count_d;
   logic                upd_branch_q, upd_branch_d;
   logic [31:0]         upd_pc_q, upd_pc_d;
   logic                upd_taken_q, upd_taken_d;
   logic                flush_q, flush_d;
   logic [31:0]         redirect_q, redirect_d;
   logic                err_q, err_d;

   logic                full;
   logic                do_alloc;
   logic                do_res;
   logic                mis;
   logic                wr_en;
   logic [31:0]         ent_pc;
   logic                ent_pred;
   logic [31:0]         ent_tgt;

   assign full     = (count_q == (PTR_BITS+1)'(DEPTH));
   assign do_alloc = bus.alloc_valid && !full;
   assign do_res   = bus.res_valid && (count_q != '0);
   assign ent_pc   = pc_q[rd_ptr_q];
   assign ent_pred = pred_q[rd_ptr_q];
   assign ent_tgt  = tgt_q[rd_ptr_q];

   // Compare the oldest entry against the actual outcome
   always_comb begin
      mis = 1'b0;
      if (do_res) begin
         mis = (bus.res_taken != ent_pred) ||
               (bus.res_taken && ent_pred && (bus.res_target != ent_tgt));
      end
   end

   // Wrong-path allocations in a squash cycle are dropped
   assign wr_en = do_alloc && !mis;

   // Next-state for pointers, occupancy and registered outputs
   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      upd_branch_d = 1'b0;
      upd_pc_d     = upd_pc_q;
      upd_taken_d  = upd_taken_q;
      flush_d      = 1'b0;
      redirect_d   = redirect_q;
      err_d        = err_q | (bus.res_valid && (count_q == '0));
      if (mis) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_alloc) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
         if (do_res)   rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
         count_d = count_q + (PTR_BITS+1)'(do_alloc)
                           - (PTR_BITS+1)'(do_res);
      end
      if (do_res) begin
         upd_branch_d = 1'b1;
         upd_pc_d     = ent_pc;
         upd_taken_d  = bus.res_taken;
      end
      if (mis) begin
         flush_d    = 1'b1;
         redirect_d = bus.res_taken ? bus.res_target : ent_pc + 32'd4;
      end
   end

   // Control state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         upd_branch_q <= 1'b0;
         upd_pc_q     <= '0;
         upd_taken_q  <= 1'b0;
         flush_q      <= 1'b0;
         redirect_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         upd_branch_q <= upd_branch_d;
         upd_pc_q     <= upd_pc_d;
         upd_taken_q  <= upd_taken_d;
         flush_q      <= flush_d;
         redirect_q   <= redirect_d;
         err_q        <= err_d;
      end
   end

   // Entry storage, left uninitialised on reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         pc_q[wr_ptr_q]   <= bus.alloc_pc;
         pred_q[wr_ptr_q] <= bus.alloc_pred;
         tgt_q[wr_ptr_q]  <= bus.alloc_target;
      end
   end

   assign bus.alloc_ready = !full;
   assign bus.upd_branch  = upd_branch_q;
   assign bus.upd_pc      = upd_pc_q;
   assign bus.upd_taken   = upd_taken_q;
   assign bus.flush       = flush_q;
   assign bus.redirect_pc = redirect_q;
   assign count           = count_q;
   assign err_underflow   = err_q;

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight predicted branches, between the fetch-side branch predictor and the execute stage.
- Records each predicted branch at fetch and compares it with the actual outcome at resolution.
- Drives the predictor's training port (pc, branch, branch_taken) and raises a pipeline flush/redirect on a misprediction.

Parameters:
DEPTH, 4, number of queue entries; power of two, 2..16
PTR_BITS, 2, log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alloc_valid  input  1  fetch presents a predicted branch this cycle
alloc_pc  input  32  PC of the branch
alloc_pred  input  1  predictor direction (1 = taken)
alloc_target  input  32  predicted taken target
alloc_ready  output  1  queue can accept; combinational, equals !full
res_valid  input  1  execute resolves the oldest outstanding branch
res_taken  input  1  actual direction
res_target  input  32  actual taken target
upd_branch  output  1  one-cycle training strobe to predictor
upd_pc  output  32  PC for training
upd_taken  output  1  actual direction for training
flush  output  1  one-cycle misprediction pulse
redirect_pc  output  32  correct fetch PC; valid while flush=1
count  output  PTR_BITS+1  current occupancy
err_underflow  output  1  sticky; set on res_valid while empty

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr=0, wr_ptr=0, count=0. upd_branch, upd_pc, upd_taken, flush, redirect_pc and err_underflow all 0. Entry storage is not cleared.
- Storage: circular buffer of {pc, pred, target}. Pointers wrap modulo DEPTH. count has PTR_BITS+1 bits, so full means count==DEPTH.
- Allocate: when alloc_valid && alloc_ready, write the entry at wr_ptr and increment wr_ptr. When full, alloc_valid is ignored and nothing is written.
- Resolve: when res_valid && count!=0, pop the entry at rd_ptr and increment rd_ptr.
- Misprediction test: mis = (res_taken != pred) || (res_taken && pred && res_target != target).
- Outputs from a resolve, all registered (visible the cycle after res_valid):
  - upd_branch=1, upd_pc=entry.pc, upd_taken=res_taken.
  - If mis: flush=1 and redirect_pc = res_taken ? res_target : entry.pc+4 (32-bit wrap).
- flush and upd_branch are single-cycle pulses, 0 otherwise. upd_pc, upd_taken and redirect_pc hold their last value when not strobed.
- Misprediction squash, in the same edge as the pop: rd_ptr=wr_ptr=0 and count=0. Every younger entry is discarded. An allocation in that same cycle is dropped because it is wrong-path.
- Simultaneous allocate and resolve, no mispredict: both take effect and count is unchanged.
  - When full, alloc_ready is still 0 in that cycle. There is no bypass of a freed slot.
- Resolve with alloc on an empty queue: the resolve is an underflow. The new entry is not visible to it. The allocation still proceeds.
- Underflow (res_valid while count==0): no pop, no upd_branch, no flush. err_underflow is set and stays 1 until reset.
- Reset asserted mid-operation: all state clears immediately. No training strobe or flush is emitted for dropped entries.
- Consumer contract: the predictor updates its table on upd_branch using upd_pc[5:2] as index. This block guarantees at most one training strobe per cycle.

Test Plan:
1. Reset, then 4 allocs (pc 0x100, 0x104, 0x108, 0x10C; pred 0) -> count 0,1,2,3,4; alloc_ready=0 after the 4th; a 5th alloc (pc 0x110) is ignored and count stays 4.
2. Full queue, resolve res_taken=0 on each in turn -> next-cycle upd_branch=1 with upd_pc 0x100, 0x104, 0x108, 0x10C in order, upd_taken=0, flush=0; count ends at 0.
3. Alloc pc 0x200, pred 0; resolve res_taken=1, res_target 0x400 -> next cycle flush=1, redirect_pc=0x400, upd_pc=0x200, upd_taken=1; count=0.
4. Alloc pc 0x300, pred 1, target 0x500, plus two younger entries; resolve res_taken=1, res_target 0x504 -> flush=1, redirect_pc=0x504, count=0, younger entries squashed. Repeat with pred 1 and res_taken=0 -> redirect_pc=0x304.
5. Same-cycle alloc and resolve at count=2 with correct prediction -> count stays 2; FIFO order kept across pointer wrap (run 10 alloc/resolve pairs).
6. res_valid on an empty queue -> err_underflow=1 and stays 1; no upd_branch or flush. Then assert rst_n=0 mid-stream with count=3 -> all outputs 0 immediately, count=0.
